// File: rtl/tank_pkg.sv
// Shared constants and types for the tank keyboard command path: direction
// codes, PS/2 framing bytes, arrow scan codes and the FSM state encodings.
package tank_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int CMD_VALID = 2;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] PS2_ARROW_UP    = 8'h75;
    localparam logic [7:0] PS2_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] PS2_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_ARROW_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        DEC_BASE    = 2'd0,
        DEC_BRK     = 2'd1,
        DEC_EXT     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_READY = 2'd1,
        CMD_ISSUE = 2'd2,
        CMD_BUSY  = 2'd3
    } cmd_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } key_hit_t;

    // Fixed priority among held keys: up > down > left > right.
    function automatic logic [1:0] prio_dir(input logic [3:0] held);
        if (held[0])
            return DIR_UP;
        else if (held[1])
            return DIR_DOWN;
        else if (held[2])
            return DIR_LEFT;
        else
            return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/tank_key_commander_ps2_key_tracker.sv
// PS/2 scan decoder: tracks held movement keys and the most recent make code.
// Define TANK_ARROW_KEYS_EN to also accept E0-prefixed arrow keys.
module ps2_key_tracker #(
    parameter logic [7:0] KEY_UP    = 8'h1D,
    parameter logic [7:0] KEY_DOWN  = 8'h1B,
    parameter logic [7:0] KEY_LEFT  = 8'h1C,
    parameter logic [7:0] KEY_RIGHT = 8'h23
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       clr_pending,
    output logic [3:0] held_keys,
    output logic       pend_valid,
    output logic [1:0] pend_dir
);
    import tank_pkg::*;

`ifdef TANK_ARROW_KEYS_EN
    localparam bit ARROWS_EN = 1'b1;
`else
    localparam bit ARROWS_EN = 1'b0;
`endif

    dec_state_t state;
    key_hit_t   wasd_hit;
    key_hit_t   arrow_hit;
    logic       load_pend;
    logic [1:0] load_dir;

    function automatic key_hit_t lookup_wasd(input logic [7:0] code);
        key_hit_t r;
        r = '{hit: 1'b0, dir: DIR_UP};
        if (code == KEY_UP)
            r = '{hit: 1'b1, dir: DIR_UP};
        else if (code == KEY_DOWN)
            r = '{hit: 1'b1, dir: DIR_DOWN};
        else if (code == KEY_LEFT)
            r = '{hit: 1'b1, dir: DIR_LEFT};
        else if (code == KEY_RIGHT)
            r = '{hit: 1'b1, dir: DIR_RIGHT};
        return r;
    endfunction

    function automatic key_hit_t lookup_arrow(input logic [7:0] code);
        key_hit_t r;
        r = '{hit: 1'b0, dir: DIR_UP};
        if (code == PS2_ARROW_UP)
            r = '{hit: 1'b1, dir: DIR_UP};
        else if (code == PS2_ARROW_DOWN)
            r = '{hit: 1'b1, dir: DIR_DOWN};
        else if (code == PS2_ARROW_LEFT)
            r = '{hit: 1'b1, dir: DIR_LEFT};
        else if (code == PS2_ARROW_RIGHT)
            r = '{hit: 1'b1, dir: DIR_RIGHT};
        return r;
    endfunction

    always_comb begin
        wasd_hit  = lookup_wasd(scan_code);
        arrow_hit = lookup_arrow(scan_code);
        load_pend = 1'b0;
        load_dir  = wasd_hit.dir;
        if (scan_valid) begin
            if (state == DEC_BASE && scan_code != PS2_BREAK && scan_code != PS2_EXT
                && wasd_hit.hit) begin
                load_pend = 1'b1;
                load_dir  = wasd_hit.dir;
            end else if (ARROWS_EN && state == DEC_EXT && scan_code != PS2_BREAK
                         && arrow_hit.hit) begin
                load_pend = 1'b1;
                load_dir  = arrow_hit.dir;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= DEC_BASE;
            held_keys <= 4'b0000;
        end else if (scan_valid) begin
            case (state)
                DEC_BASE: begin
                    if (scan_code == PS2_BREAK)
                        state <= DEC_BRK;
                    else if (scan_code == PS2_EXT)
                        state <= DEC_EXT;
                    else if (wasd_hit.hit)
                        held_keys[wasd_hit.dir] <= 1'b1;
                end
                DEC_BRK: begin
                    if (wasd_hit.hit)
                        held_keys[wasd_hit.dir] <= 1'b0;
                    state <= DEC_BASE;
                end
                DEC_EXT: begin
                    if (scan_code == PS2_BREAK) begin
                        state <= DEC_EXT_BRK;
                    end else begin
                        if (ARROWS_EN && arrow_hit.hit)
                            held_keys[arrow_hit.dir] <= 1'b1;
                        state <= DEC_BASE;
                    end
                end
                DEC_EXT_BRK: begin
                    if (ARROWS_EN && arrow_hit.hit)
                        held_keys[arrow_hit.dir] <= 1'b0;
                    state <= DEC_BASE;
                end
                default: state <= DEC_BASE;
            endcase
        end
    end

    // A make code arriving in the same cycle as an issue wins over the clear.
    always_ff @(posedge clk) begin
        if (!resetn)
            pend_valid <= 1'b0;
        else if (load_pend)
            pend_valid <= 1'b1;
        else if (clr_pending)
            pend_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (load_pend)
            pend_dir <= load_dir;
    end

endmodule

// File: rtl/tank_key_commander.sv
// Keyboard-to-tank command initiator: issues direction commands and waits for
// the tank's moving acknowledge. TANK_ARROW_KEYS_EN enables arrow keys.
module tank_key_commander #(
    parameter logic [7:0] KEY_UP      = 8'h1D,
    parameter logic [7:0] KEY_DOWN    = 8'h1B,
    parameter logic [7:0] KEY_LEFT    = 8'h1C,
    parameter logic [7:0] KEY_RIGHT   = 8'h23,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       moving,
    output logic [2:0] direction,
    output logic [3:0] held_keys,
    output logic       ack_error
);
    import tank_pkg::*;

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    cmd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             pend_valid;
    logic [1:0]       pend_dir;
    logic             issue_now;
    logic [1:0]       issue_dir;

    ps2_key_tracker #(
        .KEY_UP    (KEY_UP),
        .KEY_DOWN  (KEY_DOWN),
        .KEY_LEFT  (KEY_LEFT),
        .KEY_RIGHT (KEY_RIGHT)
    ) u_tracker (
        .clk         (clk),
        .resetn      (resetn),
        .scan_valid  (scan_valid),
        .scan_code   (scan_code),
        .clr_pending (issue_now),
        .held_keys   (held_keys),
        .pend_valid  (pend_valid),
        .pend_dir    (pend_dir)
    );

    // The latest make code takes precedence over the held-key priority.
    always_comb begin
        issue_dir = pend_valid ? pend_dir : prio_dir(held_keys);
        issue_now = (state == CMD_READY) && (pend_valid || (held_keys != 4'b0000));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= CMD_IDLE;
            direction <= 3'b000;
            ack_error <= 1'b0;
            cnt       <= '0;
        end else begin
            ack_error <= 1'b0;
            case (state)
                CMD_IDLE: begin
                    if (start)
                        state <= CMD_READY;
                end
                CMD_READY: begin
                    if (issue_now) begin
                        direction <= {1'b1, issue_dir};
                        cnt       <= '0;
                        state     <= CMD_ISSUE;
                    end
                end
                CMD_ISSUE: begin
                    if (moving) begin
                        direction <= 3'b000;
                        state     <= CMD_BUSY;
                    end else if (cnt == CNT_LAST) begin
                        direction <= 3'b000;
                        ack_error <= 1'b1;
                        state     <= CMD_READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CMD_BUSY: begin
                    if (!moving)
                        state <= CMD_READY;
                end
                default: state <= CMD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tank_key_commander.sv
// Bench for tank_key_commander: directed scenarios then random traffic, all
// checked every cycle against a behavioural model of the key/command rules.
module tb_tank_key_commander;
    localparam int TO = 15;
`ifdef TANK_ARROW_KEYS_EN
    localparam bit ARROWS = 1'b1;
`else
    localparam bit ARROWS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       moving = 1'b0;
    logic [2:0] direction;
    logic [3:0] held_keys;
    logic       ack_error;

    tank_key_commander #(.ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .moving     (moving),
        .direction  (direction),
        .held_keys  (held_keys),
        .ack_error  (ack_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: prefix flags, held set, last make, command progress.
    bit         m_ext = 0, m_brk = 0, m_pv = 0;
    bit [3:0]   m_held = 0;
    logic [1:0] m_pd = 0;
    bit         m_started = 0, m_waiting = 0, m_busy = 0, m_err = 0;
    int         m_cnt = 0;
    logic [2:0] m_dir = 0;

    // Bench tank: acknowledges ack_delay cycles after a command, busy_len long.
    int ack_delay = -1, busy_len = 20, tank_phase = 0, wcnt = 0, bcnt = 0;
    logic [2:0] last_cmd = 0;
    int err_count = 0, issue_count = 0;
    bit prev_v = 0;

    function automatic int find_key(input logic [7:0] code, input bit arrow);
        if (!arrow) begin
            case (code)
                8'h1D: return 0;
                8'h1B: return 1;
                8'h1C: return 2;
                8'h23: return 3;
                default: return -1;
            endcase
        end else begin
            case (code)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
    endfunction

    task automatic press(input int k);
        m_held[k] = 1'b1;
        m_pv = 1'b1;
        m_pd = 2'(k);
    endtask

    task automatic model_step();
        int w, a, k;
        if (!resetn) begin
            m_ext = 0; m_brk = 0; m_pv = 0; m_held = 0; m_pd = 0;
            m_started = 0; m_waiting = 0; m_busy = 0; m_err = 0; m_cnt = 0; m_dir = 0;
            return;
        end
        m_err = 0;
        k = -1;
        if (!m_started) begin
            if (start) m_started = 1;
        end else if (m_waiting) begin
            if (moving) begin
                m_dir = 0; m_waiting = 0; m_busy = 1;
            end else if (m_cnt == TO - 1) begin
                m_dir = 0; m_err = 1; m_waiting = 0;
            end else begin
                m_cnt++;
            end
        end else if (m_busy) begin
            if (!moving) m_busy = 0;
        end else begin
            if (m_pv) begin
                k = int'(m_pd);
            end else begin
                for (int b = 3; b >= 0; b--)
                    if (m_held[b]) k = b;
            end
            if (k >= 0) begin
                m_dir = {1'b1, 2'(k)};
                m_waiting = 1; m_cnt = 0; m_pv = 0;
            end
        end
        if (scan_valid) begin
            w = find_key(scan_code, 1'b0);
            a = find_key(scan_code, 1'b1);
            if (!m_ext && !m_brk) begin
                if (scan_code == 8'hF0) m_brk = 1;
                else if (scan_code == 8'hE0) m_ext = 1;
                else if (w >= 0) press(w);
            end else if (!m_ext) begin
                if (w >= 0) m_held[w] = 1'b0;
                m_brk = 0;
            end else if (!m_brk) begin
                if (scan_code == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    m_ext = 0;
                    if (ARROWS && a >= 0) press(a);
                end
            end else begin
                if (ARROWS && a >= 0) m_held[a] = 1'b0;
                m_ext = 0; m_brk = 0;
            end
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input bit sv, input logic [7:0] code);
        if (tank_phase == 1) begin
            if (wcnt <= 0) begin tank_phase = 2; bcnt = busy_len; end
            else wcnt--;
        end
        if (tank_phase == 2) begin
            if (bcnt == 0) tank_phase = 0;
            else bcnt--;
        end
        moving = (tank_phase == 2);
        scan_valid = sv;
        scan_code = code;
        @(posedge clk);
        model_step();
        #1;
        expect_val("direction", 32'(direction), 32'(m_dir));
        expect_val("held_keys", 32'(held_keys), 32'(m_held));
        expect_val("ack_error", 32'(ack_error), 32'(m_err));
        if (direction[2]) last_cmd = direction;
        if (direction[2] && !prev_v) issue_count++;
        prev_v = direction[2];
        if (ack_error) err_count++;
        if (tank_phase == 0 && direction[2] && ack_delay >= 1) begin
            tank_phase = 1;
            wcnt = ack_delay - 1;
        end
    endtask

    task automatic send(input logic [7:0] code);
        tick(1'b1, code);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, err0;
        logic [7:0] pool [11];
        pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hE0, 8'h00};

        // Reset state
        resetn = 1'b0;
        idle(3);
        expect_val("reset_dir", 32'(direction), 0);
        expect_val("reset_held", 32'(held_keys), 0);
        resetn = 1'b1;

        // No command before start; up issued within 2 cycles of start
        send(8'h1D);
        idle(5);
        expect_val("idle_held", 32'(held_keys), 32'h1);
        expect_val("idle_dir", 32'(direction), 0);
        ack_delay = 2; busy_len = 20;
        issue_count = 0; err0 = err_count;
        start = 1'b1;
        idle(2);
        expect_val("start_cmd", 32'(direction), 32'h4);
        send(8'hF0); send(8'h1D);
        idle(60);
        expect_val("one_cmd", issue_count, 1);
        expect_val("ack_clear", 32'(direction), 0);
        expect_val("no_err", err_count, err0);

        // Held left+right: left by priority, then right after left released
        busy_len = 3;
        send(8'h1C); send(8'h23);
        idle(80);
        expect_val("prio_left", 32'(last_cmd), 32'h6);
        send(8'hF0); send(8'h1C);
        idle(40);
        expect_val("prio_right", 32'(last_cmd), 32'h7);
        send(8'hF0); send(8'h23);
        idle(30);

        // Timeout: no acknowledge
        ack_delay = -1;
        send(8'h1B);
        n = 0;
        while (!direction[2] && n < 10) begin idle(1); n++; end
        expect_val("to_issue", 32'(direction[2]), 1);
        n = 0;
        while (!ack_error && n < 2 * TO) begin idle(1); n++; end
        expect_val("to_cycles", n, TO);
        idle(1);
        expect_val("to_reissue", 32'(direction), 32'h5);
        send(8'hF0); send(8'h1B);
        idle(2 * TO + 4);

        // Make code during BUSY is retained in pending
        ack_delay = 2; busy_len = 20;
        issue_count = 0;
        send(8'h1C); send(8'hF0); send(8'h1C);
        n = 0;
        while (!moving && n < 20) begin idle(1); n++; end
        expect_val("busy_wait", 32'(moving), 1);
        send(8'h1B); send(8'hF0); send(8'h1B);
        idle(60);
        expect_val("busy_pend", 32'(last_cmd), 32'h5);
        expect_val("busy_cnt", issue_count, 2);

        // Extended arrow key
        busy_len = 3;
        issue_count = 0;
        send(8'hE0); send(8'h75);
        expect_val("arrow_held", 32'(held_keys), ARROWS ? 32'h1 : 32'h0);
        idle(3);
        expect_val("arrow_cmd", issue_count, ARROWS ? 1 : 0);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(20);
        expect_val("arrow_rel", 32'(held_keys), 0);

        // Reset drops a half-received break
        send(8'hF0);
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        send(8'h1D);
        expect_val("rst_brk", 32'(held_keys), 32'h1);
        send(8'hF0); send(8'h1D);
        idle(30);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 49) == 0) start = 1'($urandom_range(0, 3) != 0);
            if (tank_phase == 0) begin
                ack_delay = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, TO + 3));
                busy_len = $urandom_range(0, 10);
            end
            if ($urandom_range(0, 3) == 0) begin
                n = $urandom_range(0, 10);
                if (n == 10) send(8'($urandom));
                else send(pool[n]);
            end else begin
                tick(1'b0, 8'($urandom));
            end
        end
        resetn = 1'b1;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
